// File: rtl/fp_mul_arbiter_if.sv
// Requester, multiplier and response signals of fp_mul_arbiter.
// The slave modport is the arbiter side; master is the requesters/multiplier/consumer side.
interface fp_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_X;
    logic [32*NUM_REQ-1:0] req_Y;
    logic [3*NUM_REQ-1:0]  req_rmode;

    logic [31:0]           mul_X;
    logic [31:0]           mul_Y;
    logic [2:0]            mul_rmode;
    logic [31:0]           mul_Z;
    logic                  mul_ovrf;
    logic                  mul_udrf;
    logic                  mul_busy;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_Z;
    logic                  rsp_ovrf;
    logic                  rsp_udrf;

    modport slave (
        input  req_valid, req_X, req_Y, req_rmode, mul_Z, mul_ovrf, mul_udrf, rsp_ready,
        output req_ready, mul_X, mul_Y, mul_rmode, mul_busy,
               rsp_valid, rsp_id, rsp_Z, rsp_ovrf, rsp_udrf
    );

    modport master (
        output req_valid, req_X, req_Y, req_rmode, mul_Z, mul_ovrf, mul_udrf, rsp_ready,
        input  req_ready, mul_X, mul_Y, mul_rmode, mul_busy,
               rsp_valid, rsp_id, rsp_Z, rsp_ovrf, rsp_udrf
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one multicycle combinational FP multiplier among NUM_REQ requesters.
// Optional zero-product bypass: define FPMUL_ARB_ZERO_BYPASS_EN.
module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_mul_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
    } op_t;

    typedef struct packed {
        logic [31:0] z;
        logic        ovrf;
        logic        udrf;
    } res_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] op_id;
    logic [3:0]      cnt;
    op_t             op_q;
    res_t            res_q;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    op_t             gnt_op;
    logic            zero_byp;
    int              idx;

    // First asserted valid after last_grant, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        gnt_op.x  = bus.req_X[32*gnt_idx +: 32];
        gnt_op.y  = bus.req_Y[32*gnt_idx +: 32];
        gnt_op.rm = bus.req_rmode[3*gnt_idx +: 3];
    end

`ifdef FPMUL_ARB_ZERO_BYPASS_EN
    // A zero operand times anything finite (or denormal) is a signed zero; no multiplier needed.
    assign zero_byp = ((gnt_op.x[30:23] == 8'h00) && (gnt_op.y[30:23] != 8'hFF)) ||
                      ((gnt_op.y[30:23] == 8'h00) && (gnt_op.x[30:23] != 8'hFF));
`else
    assign zero_byp = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    bus.req_ready[gnt_idx] = rst_n;
                    state_nxt = zero_byp ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) state_nxt = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            op_id      <= '0;
            cnt        <= '0;
            op_q       <= '0;
            res_q      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        op_q       <= gnt_op;
                        op_id      <= gnt_idx;
                        last_grant <= gnt_idx;
                        cnt        <= 4'(MUL_LAT - 1);
                        if (zero_byp) begin
                            res_q.z    <= {gnt_op.x[31] ^ gnt_op.y[31], 31'b0};
                            res_q.ovrf <= 1'b0;
                            res_q.udrf <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res_q.z    <= bus.mul_Z;
                        res_q.ovrf <= bus.mul_ovrf;
                        res_q.udrf <= bus.mul_udrf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mul_X     = op_q.x;
    assign bus.mul_Y     = op_q.y;
    assign bus.mul_rmode = op_q.rm;
    assign bus.mul_busy  = (state == BUSY);

    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_id    = op_id;
    assign bus.rsp_Z     = res_q.z;
    assign bus.rsp_ovrf  = res_q.ovrf;
    assign bus.rsp_udrf  = res_q.udrf;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: a MUL_LAT=3 four-requester instance with a constant
// multiplier stub and a MUL_LAT=1 two-requester instance whose stub changes every cycle.
module tb_fp_mul_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    logic [31:0] stub_z;
    logic        stub_o;
    logic        stub_u;
    logic [31:0] cyc;
    logic [31:0] exp_z;
    logic        found;
    logic        saw_busy;
    int          ord [5];

    fp_mul_arbiter_if #(.NUM_REQ(4)) bus_a ();
    fp_mul_arbiter_if #(.NUM_REQ(2)) bus_b ();

    fp_mul_arbiter #(.NUM_REQ(4), .MUL_LAT(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    fp_mul_arbiter #(.NUM_REQ(2), .MUL_LAT(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_a.mul_Z    = stub_z;
    assign bus_a.mul_ovrf = stub_o;
    assign bus_a.mul_udrf = stub_u;
    assign bus_b.mul_Z    = {16'hA000, cyc[15:0]};
    assign bus_b.mul_ovrf = 1'b1;
    assign bus_b.mul_udrf = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        cyc = 0;
        rst_n = 1'b0;
        stub_z = 0; stub_o = 0; stub_u = 0;
        bus_a.req_valid = '0; bus_a.req_X = '0; bus_a.req_Y = '0; bus_a.req_rmode = '0;
        bus_a.rsp_ready = 1'b0;
        bus_b.req_valid = '0; bus_b.req_X = '0; bus_b.req_Y = '0; bus_b.req_rmode = '0;
        bus_b.rsp_ready = 1'b0;
        ord = '{0, 1, 2, 3, 0};
        tick(); tick();

        // reset state, with a request pending that must not be acknowledged
        bus_a.req_valid = 4'b0001;
        #1;
        chk("rst_ready",  bus_a.req_ready, 4'b0000);
        chk("rst_valid",  bus_a.rsp_valid, 1'b0);
        chk("rst_busy",   bus_a.mul_busy,  1'b0);
        chk("rst_mulx",   bus_a.mul_X,     32'h0);
        chk("rst_rspz",   bus_a.rsp_Z,     32'h0);
        chk("rst_rspid",  bus_a.rsp_id,    2'd0);
        bus_a.req_valid = '0;
        rst_n = 1'b1;
        tick();

        // basic op on requester 0: 3.0 * 3.0, RTZ
        bus_a.req_X[31:0] = 32'h40400000;
        bus_a.req_Y[31:0] = 32'h40400000;
        bus_a.req_rmode[2:0] = 3'b001;
        bus_a.req_valid = 4'b0001;
        stub_z = 32'h41100000;
        #1;
        chk("t1_ready", bus_a.req_ready, 4'b0001);
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 1) begin
                bus_a.req_valid = 4'b0010;
                bus_a.req_X[63:32] = 32'h3F800000;
                chk("t1_mulx",  bus_a.mul_X,     32'h40400000);
                chk("t1_mulrm", bus_a.mul_rmode, 3'b001);
            end
            chk("t1_vld",   bus_a.rsp_valid, (e == 4));
            chk("t1_busy",  bus_a.mul_busy,  (e < 4));
            chk("t1_noack", bus_a.req_ready, 4'b0000);
        end
        chk("t1_id",   bus_a.rsp_id,   2'd0);
        chk("t1_z",    bus_a.rsp_Z,    32'h41100000);
        chk("t1_ovrf", bus_a.rsp_ovrf, 1'b0);
        chk("t1_udrf", bus_a.rsp_udrf, 1'b0);

        // backpressure: response held, no grant while blocked
        stub_z = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_vld",   bus_a.rsp_valid, 1'b1);
            chk("bp_z",     bus_a.rsp_Z,     32'h41100000);
            chk("bp_id",    bus_a.rsp_id,    2'd0);
            chk("bp_noack", bus_a.req_ready, 4'b0000);
        end
        bus_a.rsp_ready = 1'b1;
        tick();
        chk("bp_released", bus_a.rsp_valid, 1'b0);
        chk("bp_resume",   bus_a.req_ready, 4'b0010);

        // reset while BUSY with cnt==1 abandons the op
        tick();
        tick();
        chk("rb_busy", bus_a.mul_busy, 1'b1);
        chk("rb_mulx", bus_a.mul_X,    32'h3F800000);
        rst_n = 1'b0;
        #1;
        chk("rb_busy0",  bus_a.mul_busy,  1'b0);
        chk("rb_vld0",   bus_a.rsp_valid, 1'b0);
        chk("rb_ready0", bus_a.req_ready, 4'b0000);
        chk("rb_mulx0",  bus_a.mul_X,     32'h0);
        bus_a.req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rb_norsp", bus_a.rsp_valid, 1'b0);

        // all requesters held: order 0,1,2,3,0
        bus_a.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            stub_z = 32'h40000000 + 32'(i);
            stub_u = (i == 2);
            #1;
            chk("rr_ready", bus_a.req_ready, 4'b0001 << ord[i]);
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                tick();
                if (bus_a.rsp_valid) found = 1'b1;
                else chk("rr_onehot_busy", bus_a.req_ready, 4'b0000);
            end
            chk("rr_done", found,          1'b1);
            chk("rr_id",   bus_a.rsp_id,   ord[i][1:0]);
            chk("rr_z",    bus_a.rsp_Z,    32'h40000000 + 32'(i));
            chk("rr_udrf", bus_a.rsp_udrf, (i == 2));
            chk("rr_noack_done", bus_a.req_ready, 4'b0000);
            tick();
        end
        bus_a.req_valid = '0;
        stub_u = 1'b0;

        // zero operand on requester 1
        bus_a.req_X[63:32] = 32'h00000000;
        bus_a.req_Y[63:32] = 32'hC0490FDB;
        bus_a.req_valid = 4'b0010;
        stub_z = 32'h12345678;
        stub_o = 1'b1;
        bus_a.rsp_ready = 1'b0;
        #1;
        chk("zb_ready", bus_a.req_ready, 4'b0010);
        saw_busy = 1'b0;
`ifdef FPMUL_ARB_ZERO_BYPASS_EN
        for (int e = 1; e <= 1; e++) begin
            tick();
            bus_a.req_valid = '0;
            saw_busy = saw_busy | bus_a.mul_busy;
            chk("zb_vld", bus_a.rsp_valid, 1'b1);
        end
        chk("zb_busy", saw_busy,       1'b0);
        chk("zb_z",    bus_a.rsp_Z,    32'h80000000);
        chk("zb_ovrf", bus_a.rsp_ovrf, 1'b0);
`else
        for (int e = 1; e <= 4; e++) begin
            tick();
            bus_a.req_valid = '0;
            saw_busy = saw_busy | bus_a.mul_busy;
            chk("zb_vld", bus_a.rsp_valid, (e == 4));
        end
        chk("zb_busy", saw_busy,       1'b1);
        chk("zb_z",    bus_a.rsp_Z,    32'h12345678);
        chk("zb_ovrf", bus_a.rsp_ovrf, 1'b1);
`endif
        chk("zb_id", bus_a.rsp_id, 2'd1);
        bus_a.rsp_ready = 1'b1;
        tick();
        chk("zb_release", bus_a.rsp_valid, 1'b0);

        // MUL_LAT=1: captured product is the stub value of the single BUSY cycle
        bus_b.req_X[31:0] = 32'h40000000;
        bus_b.req_Y[31:0] = 32'h40000000;
        bus_b.req_valid = 2'b01;
        bus_b.rsp_ready = 1'b1;
        #1;
        chk("l1_ready", bus_b.req_ready, 2'b01);
        tick();
        bus_b.req_valid = '0;
        chk("l1_busy", bus_b.mul_busy, 1'b1);
        exp_z = {16'hA000, cyc[15:0]};
        tick();
        chk("l1_vld",  bus_b.rsp_valid, 1'b1);
        chk("l1_z",    bus_b.rsp_Z,     exp_z);
        chk("l1_ovrf", bus_b.rsp_ovrf,  1'b1);
        chk("l1_id",   bus_b.rsp_id,    1'b0);
        tick();
        chk("l1_release", bus_b.rsp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
